// File: rtl/right_shift_seq_pkg.sv
// rtl/right_shift_seq_pkg.sv - shared op/state encodings for the right shifter
//
// Purpose: Op encodings shared with the left shifter and ALU decode, FSM
//          state type, and a most-significant-set-bit helper used by the
//          early-exit build (SHIFT_EARLY_EXIT_EN).
// Ports:   none (package)
package right_shift_seq_pkg;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Index of the highest set bit; 0 when no bit is set.
  function automatic int unsigned msb_pos(input logic [31:0] v);
    int unsigned p;
    p = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) p = i;
    end
    return p;
  endfunction

endpackage

// File: rtl/right_shift_seq_stage.sv
// rtl/right_shift_seq_stage.sv - one binary-weighted right-shift stage
//
// Purpose: combinational stage that shifts work right by 2**k when enable
//          is set, filling vacated MSBs per op (SRL zero, SRA sign, ROR
//          wrapped LSBs). Reserved op 2'b11 behaves as SRL.
// Ports:
//   work   in  WIDTH  word entering the stage
//   enable in  1      apply this stage (Cnt[k])
//   k      in  CNTW   stage index, shift amount is 2**k
//   op     in  2      operation select
//   result out WIDTH  word leaving the stage
module right_stage
  import right_shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic [WIDTH-1:0] work,
  input  logic             enable,
  input  logic [CNTW-1:0]  k,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);

  logic [CNTW:0]      amt;
  logic [CNTW:0]      rot_amt;
  logic [WIDTH-1:0]   shifted;

  always_comb begin
    amt     = (CNTW+1)'(1) << k;
    // Amount is at most WIDTH/2, so the wrap distance never reaches zero.
    rot_amt = (CNTW+1)'(WIDTH) - amt;
    case (op)
      OP_SRA:  shifted = $unsigned($signed(work) >>> amt);
      OP_ROR:  shifted = (work >> amt) | (work << rot_amt);
      default: shifted = work >> amt;
    endcase
    result = enable ? shifted : work;
  end

endmodule

// File: rtl/right_shift_seq.sv
// rtl/right_shift_seq.sv - multi-cycle SRL/SRA/ROR shifter, one stage per clock
//
// Purpose: start/busy/done sequenced right shifter. A single right_stage is
//          reused for stages k = 0..CNTW-1. Build option SHIFT_EARLY_EXIT_EN
//          stops after the stage at the highest set bit of the latched Cnt.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous reset, active-high
//   start in  1      request, accepted only when busy=0
//   In    in  WIDTH  operand, sampled on accept
//   Cnt   in  CNTW   shift amount, sampled on accept
//   Op    in  2      00 SRL, 01 SRA, 10 ROR, 11 as SRL
//   busy  out 1      stages in progress
//   done  out 1      one-cycle completion pulse
//   Out   out WIDTH  result register
module right_shift_seq
  import right_shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNTW-1:0]  Cnt,
  input  logic [1:0]       Op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out
);

  state_t            state_q, state_d;
  logic [CNTW-1:0]   k_q;
  logic [WIDTH-1:0]  work_q;
  logic [CNTW-1:0]   cnt_q;
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  stage_out;
  logic              last_stage;
  logic              accept;

  right_stage #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_stage (
    .work   (work_q),
    .enable (cnt_q[k_q]),
    .k      (k_q),
    .op     (op_q),
    .result (stage_out)
  );

  assign busy = (state_q == ST_SHIFT);

  always_comb begin
    accept = 1'b0;
`ifdef SHIFT_EARLY_EXIT_EN
    // Stages above the highest set Cnt bit would pass work through unchanged.
    last_stage = (32'(k_q) >= msb_pos(32'(cnt_q)));
`else
    last_stage = (k_q == CNTW'(CNTW-1));
`endif
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_stage) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      done    <= 1'b0;
      Out     <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (accept) begin
        work_q <= In;
        cnt_q  <= Cnt;
        op_q   <= Op;
        k_q    <= '0;
      end else if (state_q == ST_SHIFT) begin
        work_q <= stage_out;
        k_q    <= k_q + CNTW'(1);
        if (last_stage) begin
          Out  <= stage_out;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_right_shift_seq.sv
// tb/tb_right_shift_seq.sv - directed self-checking bench for right_shift_seq
module tb_right_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in_d;
  logic [3:0]  cnt_d;
  logic [1:0]  op_d;
  logic        busy;
  logic        done;
  logic [15:0] out_d;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] last_out;

  right_shift_seq #(
    .WIDTH (16),
    .CNTW  (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (in_d),
    .Cnt   (cnt_d),
    .Op    (op_d),
    .busy  (busy),
    .done  (done),
    .Out   (out_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [3:0] c);
`ifdef SHIFT_EARLY_EXIT_EN
    int m;
    m = 0;
    for (int i = 0; i < 4; i++) if (c[i]) m = i;
    return m + 2;
`else
    return 5;
`endif
  endfunction

  // Issues one request in the current cycle and returns in its done cycle.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [3:0] c,
                       input logic [1:0] o, input logic [15:0] exp);
    int n;
    start = 1'b1; in_d = a; cnt_d = c; op_d = o;
    step();
    start = 1'b0; in_d = 16'h0; cnt_d = 4'h0; op_d = 2'b00;
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " hold"}, 32'(out_d), 32'(last_out));
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, " lat"}, n, exp_lat(c));
    check({tag, " out"}, 32'(out_d), 32'(exp));
    check({tag, " busy@done"}, 32'(busy), 32'd0);
    last_out = exp;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [3:0]  c;
    logic [1:0]  o;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9] = '{
    '{16'h8000, 4'd15, 2'b01, 16'hFFFF},
    '{16'h7FFF, 4'd15, 2'b01, 16'h0000},
    '{16'h0001, 4'd4,  2'b10, 16'h1000},
    '{16'hABCD, 4'd8,  2'b10, 16'hCDAB},
    '{16'h1234, 4'd0,  2'b00, 16'h1234},
    '{16'hF000, 4'd4,  2'b11, 16'h0F00},
    '{16'h8421, 4'd5,  2'b01, 16'hFC21},
    '{16'h8001, 4'd15, 2'b10, 16'h0003},
    '{16'hFFFF, 4'd15, 2'b00, 16'h0001}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    rst = 1'b1; start = 1'b0; in_d = '0; cnt_d = '0; op_d = '0;
    step();
    step();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst out", 32'(out_d), 32'd0);
    rst = 1'b0;
    last_out = 16'h0;
    step();

    // Basic SRL and result hold
    do_op("srl1", 16'h8001, 4'd1, 2'b00, 16'h4000);
    step(); step(); step();
    check("srl1 hold T+8", 32'(out_d), 32'h4000);
    check("srl1 done T+8", 32'(done), 32'd0);

    // Table run back-to-back: each request starts in the previous done cycle
    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].c, vecs[i].o, vecs[i].exp);
    end
    step();

    // Start while busy is ignored
    start = 1'b1; in_d = 16'hABCD; cnt_d = 4'd4; op_d = 2'b01;
    step();
    start = 1'b0;
    step();
    start = 1'b1; in_d = 16'hFFFF; cnt_d = 4'd0; op_d = 2'b00;
    step();
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("ign lat", n, exp_lat(4'd4));
    check("ign out", 32'(out_d), 32'hFABC);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("ign not queued", 32'(seen), 32'd0);
    last_out = 16'hFABC;

    // Reset mid-operation
    start = 1'b1; in_d = 16'h8000; cnt_d = 4'd15; op_d = 2'b01;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst out", 32'(out_d), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    check("midrst no done", 32'(seen), 32'd0);
    last_out = 16'h0;
    do_op("after rst", 16'hABCD, 4'd8, 2'b10, 16'hCDAB);
    step();

    // Reset and start together: request dropped
    rst = 1'b1; start = 1'b1; in_d = 16'h1234; cnt_d = 4'd1; op_d = 2'b00;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst+start busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("rst+start dropped", 32'(seen), 32'd0);
    check("rst+start out", 32'(out_d), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/right_shift_seq.md
Name: right_shift_seq

Overview:
- Multi-cycle right shifter for the CPU execute stage. It is the right-direction counterpart to the combinational left logical shifter.
- Implements logical right (SRL), arithmetic right (SRA) and rotate right (ROR).
- Applies one binary-weighted stage per clock: shift by 1, then 2, then 4, then 8.
- Uses a start/busy/done handshake. The ALU sequencer issues one shift and waits for done.

Parameters:
- WIDTH, 16: data width. Must equal 2**CNTW.
- CNTW, 4: shift count width. Also equals the number of stages.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; accepted only when busy=0
- In  input  WIDTH  operand; sampled on accept
- Cnt  input  CNTW  shift amount 0..WIDTH-1; sampled on accept
- Op  input  2  00=SRL, 01=SRA, 10=ROR, 11=reserved (executes as SRL); sampled on accept
- busy  output  1  high while stages are in progress
- done  output  1  one-cycle pulse; Out valid from this cycle on
- Out  output  WIDTH  result register

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, Out=0, working/count/op registers=0.
- States:
  - IDLE: waiting for a request.
  - SHIFT: stage counter k runs 0..CNTW-1.
- Accept: start=1 and busy=0 at edge E0.
  - Latch In into work, plus Cnt and Op.
  - k<=0, go to SHIFT, busy<=1.
- SHIFT, one edge per stage:
  - If Cnt[k]=1, shift work right by 2**k. Otherwise work is unchanged.
  - Vacated MSBs: SRL fills 0; SRA fills the work[WIDTH-1] value at that stage, which equals the original sign; ROR fills with the bits shifted out of the LSB end.
  - k<=k+1.
- Completion:
  - On the edge applying stage CNTW-1: Out<=final work, done<=1, busy<=0, state<=IDLE.
  - done is high for exactly one cycle. Out holds until the next completion or reset.
  - Latency: start sampled in cycle T; busy high T+1..T+CNTW; done high in cycle T+CNTW+1 (T+5 at defaults).
- Back-to-back: busy=0 during the done cycle, so a start in that cycle is accepted. Out keeps the previous result until the new one completes.
- start while busy=1: ignored. Not queued, no error.
- Cnt=0: still runs all stages, Out=In, same latency.
- rst mid-operation: abort immediately. Reset values apply on the next edge. The in-flight result is discarded and no done is issued.
- rst and start in the same cycle: rst wins, request is dropped.
- Op=11: executes as SRL with no flag. The verification bench checks this.

Optional Feature:
- Macro: SHIFT_EARLY_EXIT_EN
- Defined:
  - SHIFT terminates after the stage equal to the highest set bit of the latched Cnt.
  - Stage cycles = max(1, msb(Cnt)+1), so done arrives in cycle T+1+stages.
  - Cnt=0 or 1 gives done at T+2; Cnt=4'b0100 gives done at T+4; Cnt>=8 gives done at T+5.
  - Results are identical to the non-early-exit build.
- Undefined: fixed latency CNTW+1 as above.
- Handshake rules are unchanged in both builds.

Decomposition:
- Shared include shift_defs.vh:
  - Op encodings: OP_SRL=2'b00, OP_SRA=2'b01, OP_ROR=2'b10.
  - State encodings: ST_IDLE, ST_SHIFT.
  - The same Op constants are reused by the left shifter and the ALU decode.
- Sub-module right_stage:
  - Combinational, one stage: inputs work, enable, amount select k, Op; output shifted word.
  - Instantiated once and driven by k, rather than CNTW times, to keep area minimal.

Test Plan:
- Basic SRL: In=16'h8001, Cnt=1, Op=SRL, start at T → busy T+1..T+4; done=1 only at T+5; Out=16'h4000; Out still 16'h4000 at T+8.
- Sign fill: SRA, In=16'h8000, Cnt=15 → Out=16'hFFFF. Repeat with In=16'h7FFF → Out=16'h0000.
- Rotate: ROR, In=16'h0001, Cnt=4 → Out=16'h1000. ROR, In=16'hABCD, Cnt=8 → Out=16'hCDAB.
- Zero count and reserved op: Cnt=0, In=16'h1234, Op=SRL → Out=16'h1234 at T+5 (T+2 with SHIFT_EARLY_EXIT_EN). Op=11, In=16'hF000, Cnt=4 → Out=16'h0F00.
- Handshake:
  - A second start at T+2 with In=16'hFFFF is ignored, and the first result is unaffected.
  - A start in the done cycle is accepted, and its done arrives 5 cycles later.
- Reset mid-op: rst=1 at T+2 → next cycle busy=0, done=0, Out=0. No done pulse follows. A new request afterwards completes normally.
